mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requester channels, legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: physical-memory beat width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-004 SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_read, input, NUM_PORTS bits: per-port read request, held until that port's req_resp.
REQ-008 SHALL have port req_write, input, NUM_PORTS bits: per-port write request, held until that port's req_resp.
REQ-009 SHALL have port req_address, input, NUM_PORTS*ADDR_WIDTH bits: port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port req_wdata, input, NUM_PORTS*DATA_WIDTH bits: port i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port req_resp, output, NUM_PORTS bits: one-cycle completion pulse to the granted port.
REQ-012 SHALL have port req_rdata, output, DATA_WIDTH bits: read data shared by all ports, valid only while a req_resp bit is high.
REQ-013 SHALL have port pmem_resp, input, 1 bit: physical-memory completion pulse.
REQ-014 SHALL have port pmem_rdata, input, DATA_WIDTH bits: physical-memory read data, valid with pmem_resp.
REQ-015 SHALL have ports pmem_read and pmem_write, outputs, 1 bit each: physical-memory commands.
REQ-016 SHALL have ports pmem_address (ADDR_WIDTH bits) and pmem_wdata (DATA_WIDTH bits), outputs: physical-memory address and write data.
REQ-017 SHALL have port grant_id, output, $clog2(NUM_PORTS) bits: index of the current or last granted port.

Function
REQ-018 SHALL implement an FSM with three states: IDLE, BUSY, DONE.
REQ-019 SHALL, in IDLE with any port requesting (req_read|req_write nonzero), select a winner, register its index, command, address and wdata, and enter BUSY on the next edge.
REQ-020 SHALL, in round-robin mode, search ports starting at (last grant + 1) mod NUM_PORTS, wrapping around; after reset the search starts at port 0.
REQ-021 SHALL, in fixed-priority mode, grant the lowest-numbered requesting port.
REQ-022 SHALL treat a port asserting both req_read and req_write as a write.
REQ-023 SHALL drive pmem_read/pmem_write, pmem_address and pmem_wdata from registers only, held constant throughout BUSY.
REQ-024 SHALL ignore request changes on all ports while in BUSY or DONE; a granted transaction always completes.
REQ-025 SHALL, in BUSY on pmem_resp, capture pmem_rdata into a register, deassert pmem_read/pmem_write on the same edge, and enter DONE.
REQ-026 SHALL, in DONE, assert req_resp for the granted port only, for exactly one cycle, with req_rdata equal to the captured data, then return to IDLE.
REQ-027 SHALL keep the latency from a request in IDLE to pmem command at 1 cycle, and from pmem_resp to req_resp at 1 cycle.
REQ-028 SHALL allow a new grant in the first IDLE cycle after DONE; a held request from the just-served port loses to any other requester in round-robin mode.
REQ-029 SHALL ignore pmem_resp in IDLE and DONE.
REQ-030 SHALL never assert pmem_read and pmem_write together, and never assert more than one req_resp bit.

Reset
REQ-031 SHALL, on rst, enter IDLE and clear pmem_read, pmem_write, pmem_address, pmem_wdata, req_resp, req_rdata and grant_id to 0, and set the round-robin pointer so that port 0 is searched first.
REQ-032 SHALL abandon any in-flight transaction on rst without issuing req_resp, with rst taking precedence over pmem_resp in the same cycle.

Verification
REQ-033 SHALL be tested with a single read: port 1 reads 0x100 and memory responds with 0xDEADBEEF_CAFEF00D after 3 cycles -> pmem_read=1 and pmem_address=0x100 from cycle 1, req_resp=2'b10 one cycle after pmem_resp, and req_rdata equal to the response data.
REQ-034 SHALL be tested with simultaneous requests in round-robin mode: ports 0 and 1 request continuously -> grants alternate 0,1,0,1.
REQ-035 SHALL be tested with simultaneous requests in fixed-priority mode (RR_MODE=0, NUM_PORTS=4): ports 1, 2 and 3 request -> port 1 is granted first, then port 2, then port 3.
REQ-036 SHALL be tested with a write: port 0 writes 0x0123456789ABCDEF to 0x2000 -> pmem_write=1 and pmem_wdata/pmem_address hold steady until pmem_resp, and pmem_read stays 0 throughout.
REQ-037 SHALL be tested with reset mid-BUSY: rst is asserted during a read -> the next cycle shows IDLE with all outputs 0 and no req_resp, and a later request is granted normally.
REQ-038 SHALL be tested with a spurious pmem_resp pulse in IDLE -> no req_resp and no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one physical-memory port between NUM_PORTS requesters,
//            round-robin or fixed-priority, one transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    input  logic                            pmem_resp,
    input  logic [DATA_WIDTH-1:0]           pmem_rdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    output logic [ADDR_WIDTH-1:0]           pmem_address,
    output logic [DATA_WIDTH-1:0]           pmem_wdata,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id
);

    localparam int               c_IDW     = $clog2(NUM_PORTS);
    localparam logic [c_IDW-1:0] c_LAST    = c_IDW'(NUM_PORTS - 1);
    localparam logic [c_IDW-1:0] c_ONE     = c_IDW'(1);
    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_BUSY = 2'd1;
    localparam logic [1:0]       c_ST_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_grant;
    logic                  w_complete;
    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_found;
    logic [c_IDW-1:0]      w_winner;
    int                    w_idx;

    // r_start is the first port searched on the next round-robin grant
    logic [c_IDW-1:0]      r_start;
    logic [c_IDW-1:0]      r_grant;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_pmem_address;
    logic [DATA_WIDTH-1:0] r_pmem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_PORTS-1:0]  r_resp;

    assign w_req = req_read | req_write;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = k + ((RR_MODE != 0) ? int'(r_start) : 0);
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            if (!w_found && w_req[w_idx[c_IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_IDW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (pmem_resp) begin
                    w_complete  = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_start        <= '0;
            r_grant        <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_rdata        <= '0;
            r_resp         <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_resp  <= '0;
            if (w_grant) begin
                // read+write together resolves to a write
                r_grant        <= w_winner;
                r_pmem_write   <= req_write[w_winner];
                r_pmem_read    <= req_read[w_winner] & ~req_write[w_winner];
                r_pmem_address <= req_address[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                r_pmem_wdata   <= req_wdata[w_winner*DATA_WIDTH +: DATA_WIDTH];
                r_start        <= (w_winner == c_LAST) ? '0 : w_winner + c_ONE;
            end
            if (w_complete) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_rdata      <= pmem_rdata;
                r_resp       <= NUM_PORTS'(1) << r_grant;
            end
        end
    end

    assign req_resp     = r_resp;
    assign req_rdata    = r_rdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign grant_id     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench: directed sequences on a 2-port RR arbiter,
//            vector table on a 4-port fixed-priority arbiter, random vs model
//            on a 3-port RR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---- instance A: 2 ports, 64b data, 32b address, round-robin
    logic [1:0]   a_req_read, a_req_write, a_req_resp;
    logic [63:0]  a_req_address;
    logic [127:0] a_req_wdata;
    logic [63:0]  a_req_rdata, a_pmem_rdata, a_pmem_wdata;
    logic         a_pmem_resp, a_pmem_read, a_pmem_write;
    logic [31:0]  a_pmem_address;
    logic [0:0]   a_grant_id;

    mem_port_arbiter u_dut_a (
        .clk(clk), .rst(rst),
        .req_read(a_req_read), .req_write(a_req_write),
        .req_address(a_req_address), .req_wdata(a_req_wdata),
        .req_resp(a_req_resp), .req_rdata(a_req_rdata),
        .pmem_resp(a_pmem_resp), .pmem_rdata(a_pmem_rdata),
        .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata),
        .grant_id(a_grant_id)
    );

    // ---- instance B: 4 ports, fixed priority
    logic [3:0]  b_req_read, b_req_write, b_req_resp;
    logic [63:0] b_req_address, b_req_wdata;
    logic [15:0] b_req_rdata, b_pmem_rdata, b_pmem_wdata, b_pmem_address;
    logic        b_pmem_resp, b_pmem_read, b_pmem_write;
    logic [1:0]  b_grant_id;

    mem_port_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(16), .ADDR_WIDTH(16), .RR_MODE(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_read(b_req_read), .req_write(b_req_write),
        .req_address(b_req_address), .req_wdata(b_req_wdata),
        .req_resp(b_req_resp), .req_rdata(b_req_rdata),
        .pmem_resp(b_pmem_resp), .pmem_rdata(b_pmem_rdata),
        .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
        .grant_id(b_grant_id)
    );

    // ---- instance C: 3 ports, round-robin, random traffic
    logic [2:0]  c_req_read, c_req_write, c_req_resp;
    logic [47:0] c_req_address, c_req_wdata;
    logic [15:0] c_req_rdata, c_pmem_rdata, c_pmem_wdata, c_pmem_address;
    logic        c_pmem_resp, c_pmem_read, c_pmem_write;
    logic [1:0]  c_grant_id;

    mem_port_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(16), .ADDR_WIDTH(16), .RR_MODE(1)) u_dut_c (
        .clk(clk), .rst(rst),
        .req_read(c_req_read), .req_write(c_req_write),
        .req_address(c_req_address), .req_wdata(c_req_wdata),
        .req_resp(c_req_resp), .req_rdata(c_req_rdata),
        .pmem_resp(c_pmem_resp), .pmem_rdata(c_pmem_rdata),
        .pmem_read(c_pmem_read), .pmem_write(c_pmem_write),
        .pmem_address(c_pmem_address), .pmem_wdata(c_pmem_wdata),
        .grant_id(c_grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serve one transaction on A with requests left as they are.
    task automatic a_serve(input int exp_g, input int lat);
        logic [63:0] rd;
        tick();
        for (int c = 0; c < 8 && !(a_pmem_read || a_pmem_write); c++) tick();
        chk("a_cmd_seen", 64'(a_pmem_read | a_pmem_write), 64'd1);
        chk("a_grant", 64'(a_grant_id), 64'(exp_g));
        chk("a_addr", 64'(a_pmem_address), 64'(a_req_address[exp_g*32 +: 32]));
        repeat (lat) tick();
        rd = 64'hC0DE_0000_0000_0000 | 64'(exp_g);
        a_pmem_resp = 1'b1;
        a_pmem_rdata = rd;
        tick();
        a_pmem_resp = 1'b0;
        chk("a_resp", 64'(a_req_resp), 64'(2'b01 << exp_g));
        chk("a_rdata", a_req_rdata, rd);
        tick();
        chk("a_resp_1cyc", 64'(a_req_resp), 64'd0);
    endtask

    // ---- fixed-priority vector table
    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        int         g;
        logic       exp_rd;
        logic       exp_wr;
    } fp_vec_t;
    fp_vec_t fp_tab[8];

    // ---- random-traffic requester state and reference model for C
    bit          c_pend[3];
    int          c_kind[3];  // 0 read, 1 write, 2 read+write
    logic [15:0] c_addr[3];
    logic [15:0] c_wd[3];
    int          c_last;

    function automatic int model_pick();
        for (int k = 1; k <= 3; k++) begin
            if (c_pend[(c_last + k) % 3]) return (c_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic c_drive();
        for (int i = 0; i < 3; i++) begin
            c_req_read[i]            = c_pend[i] && (c_kind[i] != 1);
            c_req_write[i]           = c_pend[i] && (c_kind[i] != 0);
            c_req_address[i*16 +: 16] = c_addr[i];
            c_req_wdata[i*16 +: 16]   = c_wd[i];
        end
    endtask

    task automatic c_new_reqs();
        for (int i = 0; i < 3; i++) begin
            if (!c_pend[i] && $urandom_range(0, 2) == 0) begin
                c_pend[i] = 1'b1;
                c_kind[i] = int'($urandom_range(0, 2));
                c_addr[i] = 16'($urandom);
                c_wd[i]   = 16'($urandom);
            end
        end
        c_drive();
    endtask

    initial begin
        int w;
        int lat;
        logic [15:0] rd16;

        a_req_read = '0; a_req_write = '0; a_req_address = '0; a_req_wdata = '0;
        a_pmem_resp = 1'b0; a_pmem_rdata = '0;
        b_req_read = '0; b_req_write = '0; b_pmem_resp = 1'b0; b_pmem_rdata = '0;
        b_req_address = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        b_req_wdata   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        c_pmem_resp = 1'b0; c_pmem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            c_pend[i] = 1'b0; c_kind[i] = 0; c_addr[i] = '0; c_wd[i] = '0;
        end
        c_last = 2;
        c_drive();

        fp_tab[0] = '{4'b1110, 4'b0000, 1, 1'b1, 1'b0};
        fp_tab[1] = '{4'b1100, 4'b0000, 2, 1'b1, 1'b0};
        fp_tab[2] = '{4'b1000, 4'b0000, 3, 1'b1, 1'b0};
        fp_tab[3] = '{4'b0000, 4'b1010, 1, 1'b0, 1'b1};
        fp_tab[4] = '{4'b0101, 4'b0100, 0, 1'b1, 1'b0};
        fp_tab[5] = '{4'b0100, 4'b0100, 2, 1'b0, 1'b1};
        fp_tab[6] = '{4'b1001, 4'b0000, 0, 1'b1, 1'b0};
        fp_tab[7] = '{4'b1000, 4'b1000, 3, 1'b0, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        chk("rst_a_cmd", 64'({a_pmem_read, a_pmem_write}), 64'd0);
        chk("rst_a_addr", 64'(a_pmem_address), 64'd0);
        chk("rst_a_wdata", a_pmem_wdata, 64'd0);
        chk("rst_a_resp", 64'(a_req_resp), 64'd0);
        chk("rst_a_rdata", a_req_rdata, 64'd0);
        chk("rst_a_grant", 64'(a_grant_id), 64'd0);
        chk("rst_b_cmd", 64'({b_pmem_read, b_pmem_write, b_req_resp}), 64'd0);
        chk("rst_c_cmd", 64'({c_pmem_read, c_pmem_write, c_req_resp}), 64'd0);
        rst = 1'b0;
        tick();

        // single read, memory answers in the third BUSY cycle
        a_req_address = {32'h0000_0100, 32'h0};
        a_req_read = 2'b10;
        tick();
        chk("rd_pmem_read", 64'(a_pmem_read), 64'd1);
        chk("rd_pmem_write", 64'(a_pmem_write), 64'd0);
        chk("rd_addr", 64'(a_pmem_address), 64'h100);
        chk("rd_grant", 64'(a_grant_id), 64'd1);
        tick();
        chk("rd_hold", 64'(a_pmem_read), 64'd1);
        tick();
        a_pmem_resp = 1'b1;
        a_pmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        a_pmem_resp = 1'b0;
        a_req_read = 2'b00;
        chk("rd_resp", 64'(a_req_resp), 64'h2);
        chk("rd_rdata", a_req_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("rd_cmd_drop", 64'(a_pmem_read), 64'd0);
        tick();
        chk("rd_resp_1cyc", 64'(a_req_resp), 64'd0);

        // continuous requests from both ports alternate
        a_req_address = {32'h0000_1111, 32'h0000_2222};
        a_req_read = 2'b11;
        for (int i = 0; i < 4; i++) a_serve(i % 2, i);
        a_req_read = 2'b00;

        // write: command held while request inputs wiggle
        a_req_address[31:0] = 32'h0000_2000;
        a_req_wdata[63:0]   = 64'h0123_4567_89AB_CDEF;
        a_req_write = 2'b01;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("wr_pmem_write", 64'(a_pmem_write), 64'd1);
            chk("wr_pmem_read", 64'(a_pmem_read), 64'd0);
            chk("wr_addr", 64'(a_pmem_address), 64'h2000);
            chk("wr_wdata", a_pmem_wdata, 64'h0123_4567_89AB_CDEF);
            a_req_address[31:0] = $urandom;
            a_req_wdata[63:0]   = {$urandom, $urandom};
            a_req_read = 2'b10;
            if (i == 3) a_pmem_resp = 1'b1;
            tick();
        end
        a_pmem_resp = 1'b0;
        a_req_write = 2'b00;
        chk("wr_resp", 64'(a_req_resp), 64'h1);
        chk("wr_cmd_drop", 64'({a_pmem_read, a_pmem_write}), 64'd0);
        a_serve(1, 0);
        a_req_read = 2'b00;

        // reset in BUSY, with pmem_resp in the same cycle
        a_req_read = 2'b01;
        tick();
        chk("abort_busy", 64'(a_pmem_read), 64'd1);
        rst = 1'b1;
        a_pmem_resp = 1'b1;
        tick();
        rst = 1'b0;
        a_pmem_resp = 1'b0;
        chk("abort_cmd", 64'({a_pmem_read, a_pmem_write}), 64'd0);
        chk("abort_addr", 64'(a_pmem_address), 64'd0);
        chk("abort_resp", 64'(a_req_resp), 64'd0);
        chk("abort_rdata", a_req_rdata, 64'd0);
        chk("abort_grant", 64'(a_grant_id), 64'd0);
        a_req_read = 2'b11;
        tick();
        chk("abort_no_resp", 64'(a_req_resp), 64'd0);
        chk("abort_regrant", 64'(a_grant_id), 64'd0);
        chk("abort_regrant_cmd", 64'(a_pmem_read), 64'd1);
        a_pmem_resp = 1'b1;
        tick();
        a_pmem_resp = 1'b0;
        a_req_read = 2'b00;
        chk("abort_after_resp", 64'(a_req_resp), 64'h1);
        tick();

        // spurious pmem_resp in IDLE
        a_pmem_resp = 1'b1;
        tick();
        a_pmem_resp = 1'b0;
        chk("spur_resp", 64'(a_req_resp), 64'd0);
        chk("spur_cmd", 64'({a_pmem_read, a_pmem_write}), 64'd0);
        chk("spur_grant", 64'(a_grant_id), 64'd0);
        tick();
        chk("spur_resp2", 64'(a_req_resp), 64'd0);
        a_req_read = 2'b11;
        a_serve(1, 1);
        a_req_read = 2'b00;
        tick();

        // fixed-priority table; next entry's requests appear during DONE
        b_req_read  = fp_tab[0].rd;
        b_req_write = fp_tab[0].wr;
        for (int i = 0; i < 8; i++) begin
            b_req_read  = fp_tab[i].rd;
            b_req_write = fp_tab[i].wr;
            tick();
            chk("fp_grant", 64'(b_grant_id), 64'(fp_tab[i].g));
            chk("fp_read", 64'(b_pmem_read), 64'(fp_tab[i].exp_rd));
            chk("fp_write", 64'(b_pmem_write), 64'(fp_tab[i].exp_wr));
            chk("fp_addr", 64'(b_pmem_address), 64'(16'h1000 + 16'(fp_tab[i].g)));
            chk("fp_wdata", 64'(b_pmem_wdata), 64'(16'hA000 + 16'(fp_tab[i].g)));
            b_pmem_resp = 1'b1;
            b_pmem_rdata = 16'h5A00 + 16'(i);
            tick();
            b_pmem_resp = 1'b0;
            chk("fp_resp", 64'(b_req_resp), 64'(4'b0001 << fp_tab[i].g));
            chk("fp_rdata", 64'(b_req_rdata), 64'(16'h5A00 + 16'(i)));
            b_req_read  = (i < 7) ? fp_tab[i+1].rd : 4'b0000;
            b_req_write = (i < 7) ? fp_tab[i+1].wr : 4'b0000;
            tick();
            chk("fp_resp_1cyc", 64'(b_req_resp), 64'd0);
        end

        // random traffic on C against the reference model
        for (int t = 0; t < 120; t++) begin
            c_new_reqs();
            c_pmem_resp = ($urandom_range(0, 4) == 0);
            w = model_pick();
            tick();
            c_pmem_resp = 1'b0;
            if (w < 0) begin
                chk("rnd_idle_cmd", 64'({c_pmem_read, c_pmem_write, c_req_resp}), 64'd0);
                continue;
            end
            chk("rnd_grant", 64'(c_grant_id), 64'(w));
            chk("rnd_read", 64'(c_pmem_read), 64'(c_kind[w] == 0));
            chk("rnd_write", 64'(c_pmem_write), 64'(c_kind[w] != 0));
            chk("rnd_addr", 64'(c_pmem_address), 64'(c_addr[w]));
            chk("rnd_wdata", 64'(c_pmem_wdata), 64'(c_wd[w]));
            lat = int'($urandom_range(0, 3));
            for (int j = 0; j < lat; j++) begin
                c_new_reqs();
                tick();
                chk("rnd_hold", 64'({c_pmem_read | c_pmem_write, c_pmem_address}),
                    64'({1'b1, c_addr[w]}));
            end
            rd16 = 16'($urandom);
            c_pmem_resp = 1'b1;
            c_pmem_rdata = rd16;
            tick();
            c_pmem_resp = 1'b0;
            chk("rnd_resp", 64'(c_req_resp), 64'(3'b001 << w));
            chk("rnd_rdata", 64'(c_req_rdata), 64'(rd16));
            chk("rnd_cmd_drop", 64'({c_pmem_read, c_pmem_write}), 64'd0);
            c_pend[w] = 1'b0;
            c_last = w;
            c_new_reqs();
            tick();
            chk("rnd_resp_1cyc", 64'(c_req_resp), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // keeps the run finite whatever the design does
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
